grant_resp_router: RTL and testbench

GRANT_RESP_ROUTER -- requirements
Module: grant_resp_router

---
 rtl/grant_resp_router.sv | 119 +++++++++++
 tb/tb_grant_resp_router.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/grant_resp_router.sv
// Routes in-order downstream responses back to the requester that was granted,
// by queueing granted requester indices and steering each response to the queue head.
module grant_resp_router #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       grant_valid_i,
   input  logic [$clog2(WIDTH)-1:0]   grant_idx_i,
   output logic                       issue_ready_o,
   input  logic                       resp_valid_i,
   input  logic [DATA_W-1:0]          resp_data_i,
   output logic                       resp_ready_o,
   output logic [WIDTH-1:0]           client_valid_o,
   output logic [DATA_W-1:0]          client_data_o,
   input  logic [WIDTH-1:0]           client_ready_i,
   output logic [$clog2(DEPTH):0]     outstanding_o,
   output logic                       error_o
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0] fifo_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             error_r;

   logic [IDX_W-1:0] head_s;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic             err_event_s;

   function automatic logic [WIDTH-1:0] onehot_f(input logic [IDX_W-1:0] idx);
      onehot_f = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Queue status, handshakes and routing derived from registered state and inputs.
   always_comb begin
      head_s         = fifo_r[rd_ptr_r];
      full_s         = (count_r == CNT_W'(DEPTH));
      empty_s        = (count_r == {CNT_W{1'b0}});
      issue_ready_o  = !full_s;
      resp_ready_o   = 1'b0;
      client_valid_o = {WIDTH{1'b0}};
      client_data_o  = resp_data_i;
      if (!empty_s) begin
         resp_ready_o = client_ready_i[head_s];
      end else begin
         resp_ready_o = 1'b0;
      end
      if (resp_valid_i && !empty_s) begin
         client_valid_o = onehot_f(head_s);
      end else begin
         client_valid_o = {WIDTH{1'b0}};
      end
      push_s      = grant_valid_i && !full_s;
      pop_s       = resp_valid_i && resp_ready_o;
      err_event_s = (grant_valid_i && full_s) || (resp_valid_i && empty_s);
   end

   // ID storage; entries are only meaningful between the pointers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_r[i] <= {IDX_W{1'b0}};
         end
      end else if (push_s) begin
         fifo_r[wr_ptr_r] <= grant_idx_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy counter; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky protocol-violation flag, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         error_r <= 1'b0;
      end else if (err_event_s) begin
         error_r <= 1'b1;
      end
   end

   assign outstanding_o = count_r;
   assign error_o       = error_r;

endmodule

// File: tb/tb_grant_resp_router.sv
// Scoreboard bench for grant_resp_router: granted IDs are queued when driven and
// compared against the routed one-hot valid when a response is presented.
module tb_grant_resp_router;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 64;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = 3;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              grant_valid_i;
   logic [IDX_W-1:0]  grant_idx_i;
   logic              issue_ready_o;
   logic              resp_valid_i;
   logic [DATA_W-1:0] resp_data_i;
   logic              resp_ready_o;
   logic [WIDTH-1:0]  client_valid_o;
   logic [DATA_W-1:0] client_data_o;
   logic [WIDTH-1:0]  client_ready_i;
   logic [CNT_W-1:0]  outstanding_o;
   logic              error_o;

   int checks   = 0;
   int failures = 0;
   logic [IDX_W-1:0] sb_q[$];
   logic             model_err;

   grant_resp_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .grant_valid_i  (grant_valid_i),
      .grant_idx_i    (grant_idx_i),
      .issue_ready_o  (issue_ready_o),
      .resp_valid_i   (resp_valid_i),
      .resp_data_i    (resp_data_i),
      .resp_ready_o   (resp_ready_o),
      .client_valid_o (client_valid_o),
      .client_data_o  (client_data_o),
      .client_ready_i (client_ready_i),
      .outstanding_o  (outstanding_o),
      .error_o        (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: mid-cycle output checks against the scoreboard, then model update.
   task automatic cycle(input logic gv, input logic [IDX_W-1:0] gidx, input logic rv,
                        input logic [DATA_W-1:0] rdata, input logic [WIDTH-1:0] cready);
      logic             full;
      logic             empty;
      logic             do_push;
      logic             do_pop;
      logic [IDX_W-1:0] head;
      logic [WIDTH-1:0] exp_cv;
      grant_valid_i  = gv;
      grant_idx_i    = gidx;
      resp_valid_i   = rv;
      resp_data_i    = rdata;
      client_ready_i = cready;
      @(negedge clk_i);
      full   = (sb_q.size() == DEPTH);
      empty  = (sb_q.size() == 0);
      head   = empty ? 3'd0 : sb_q[0];
      exp_cv = (rv && !empty) ? (WIDTH'(1) << head) : {WIDTH{1'b0}};
      check_val("issue_ready", 64'(issue_ready_o), 64'(!full));
      check_val("resp_ready", 64'(resp_ready_o), 64'(!empty && cready[head]));
      check_val("client_valid", 64'(client_valid_o), 64'(exp_cv));
      check_val("client_data", client_data_o, rdata);
      do_push = gv && !full;
      do_pop  = rv && !empty && cready[head];
      @(posedge clk_i);
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(gidx);
      if ((gv && full) || (rv && empty)) model_err = 1'b1;
      #1;
      check_val("outstanding", 64'(outstanding_o), 64'(sb_q.size()));
      check_val("error", 64'(error_o), 64'(model_err));
   endtask

   // Reset pulse with arbitrary grant/response activity that must have no effect.
   task automatic do_reset(input logic gv, input logic rv);
      rst_i          = 1'b1;
      grant_valid_i  = gv;
      grant_idx_i    = 3'd5;
      resp_valid_i   = rv;
      resp_data_i    = 64'h0;
      client_ready_i = 8'hFF;
      @(posedge clk_i);
      sb_q.delete();
      model_err = 1'b0;
      #1;
      rst_i         = 1'b0;
      grant_valid_i = 1'b0;
      resp_valid_i  = 1'b0;
      #1;
      check_val("rst_outstanding", 64'(outstanding_o), 64'd0);
      check_val("rst_error", 64'(error_o), 64'd0);
      check_val("rst_issue_ready", 64'(issue_ready_o), 64'd1);
      check_val("rst_resp_ready", 64'(resp_ready_o), 64'd0);
      check_val("rst_client_valid", 64'(client_valid_o), 64'd0);
   endtask

   initial begin
      rst_i = 1'b1; grant_valid_i = 1'b0; grant_idx_i = 3'd0; resp_valid_i = 1'b0;
      resp_data_i = 64'h0; client_ready_i = 8'h00; model_err = 1'b0;
      @(negedge clk_i);
      do_reset(1'b0, 1'b0);

      // In-order routing of three IDs.
      cycle(1'b1, 3'd3, 1'b0, 64'h11, 8'hFF);
      cycle(1'b1, 3'd5, 1'b0, 64'h12, 8'hFF);
      cycle(1'b1, 3'd0, 1'b0, 64'h13, 8'hFF);
      check_val("seq_outstanding3", 64'(outstanding_o), 64'd3);
      cycle(1'b0, 3'd0, 1'b1, 64'hA1, 8'hFF);
      cycle(1'b0, 3'd0, 1'b1, 64'hA2, 8'hFF);
      cycle(1'b0, 3'd0, 1'b1, 64'hA3, 8'hFF);
      check_val("seq_outstanding0", 64'(outstanding_o), 64'd0);

      // Fill, then overflow grant.
      cycle(1'b1, 3'd1, 1'b0, 64'h0, 8'h00);
      cycle(1'b1, 3'd2, 1'b0, 64'h0, 8'h00);
      cycle(1'b1, 3'd6, 1'b0, 64'h0, 8'h00);
      cycle(1'b1, 3'd7, 1'b0, 64'h0, 8'h00);
      check_val("full_issue_ready", 64'(issue_ready_o), 64'd0);
      cycle(1'b1, 3'd4, 1'b0, 64'h0, 8'h00);
      check_val("ovf_error", 64'(error_o), 64'd1);
      check_val("ovf_outstanding", 64'(outstanding_o), 64'd4);

      // Full queue: pop and refused grant in the same cycle.
      cycle(1'b1, 3'd4, 1'b1, 64'hB0, 8'hFF);
      check_val("full_pop_outstanding", 64'(outstanding_o), 64'd3);

      // Head is 2: only its ready bit matters.
      for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1, 64'hC0 + 64'(i), 8'hFB);
      check_val("stall_outstanding", 64'(outstanding_o), 64'd3);
      cycle(1'b0, 3'd0, 1'b1, 64'hC5, 8'h04);
      check_val("unstall_outstanding", 64'(outstanding_o), 64'd2);
      cycle(1'b0, 3'd0, 1'b1, 64'hD0, 8'hFF);
      cycle(1'b0, 3'd0, 1'b1, 64'hD1, 8'hFF);

      // Response while empty.
      do_reset(1'b0, 1'b0);
      cycle(1'b0, 3'd0, 1'b1, 64'hE0, 8'hFF);
      check_val("empty_resp_error", 64'(error_o), 64'd1);

      // Reset mid-operation with activity in the reset cycle.
      do_reset(1'b0, 1'b0);
      cycle(1'b1, 3'd6, 1'b0, 64'h0, 8'h00);
      cycle(1'b1, 3'd1, 1'b0, 64'h0, 8'h00);
      do_reset(1'b1, 1'b1);

      // Push into empty queue with a same-cycle response: routed next cycle.
      cycle(1'b1, 3'd7, 1'b1, 64'hF0, 8'hFF);
      cycle(1'b0, 3'd0, 1'b1, 64'hF1, 8'hFF);
      check_val("late_route_outstanding", 64'(outstanding_o), 64'd0);

      // Random traffic against the scoreboard.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
